// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU with valid/ready handshakes and carry/zero/sign/overflow flags.
// Define ALU_SEQ_MUL_EN to turn opcode 10 into an iterative shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALUA,
    input  logic [WIDTH-1:0] ALUB,
    input  logic [3:0]       ALUControl,
    input  logic             ALUFlagIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             C,
    output logic             Z,
    output logic             S,
    output logic             V
);

    // state | meaning
    // IDLE  | in_ready high, waiting for in_valid
    // EXEC  | one shift/multiply step per cycle until cnt reaches 0, then result is latched
    // DONE  | out_valid high, outputs held until out_ready
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;
`endif

    localparam int                MSB      = WIDTH - 1;
    localparam logic [CNTW-1:0]   CNT_FULL = CNTW'(WIDTH);
    localparam logic [CNTW-1:0]   CNT_ONE  = CNTW'(1);
    localparam logic [WIDTH-1:0]  AMT_FULL = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
    localparam logic [WIDTH:0]    ONE_W1   = (WIDTH + 1)'(1);

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [3:0]        op_q;
    logic              fin_q;
    logic              carry_q;
    logic [CNTW-1:0]   cnt;

    logic [CNTW-1:0]   steps;
    logic [WIDTH-1:0]  opnd;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  res;
    logic              cf;
    logic              vf;

`ifdef ALU_SEQ_MUL_EN
    // a_q holds the multiplicand, {acc_q, b_q} is the shifting partial product
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH:0]    mul_sum;

    always_comb begin
        mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
    end
`endif

    // Step count loaded on accept; a shift amount beyond WIDTH saturates
    always_comb begin
        steps = '0;
        if (ALUControl == OP_SHL || ALUControl == OP_SHR)
            steps = (ALUB >= AMT_FULL) ? CNT_FULL : ALUB[CNTW-1:0];
`ifdef ALU_SEQ_MUL_EN
        if (ALUControl == OP_MUL)
            steps = CNT_FULL;
`endif
    end

    always_comb begin
        opnd = fin_q ? b_q : a_q;
        sum  = '0;
        res  = '0;
        cf   = 1'b0;
        vf   = 1'b0;
        case (op_q)
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_ADD: begin
                sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, fin_q};
                res = sum[WIDTH-1:0];
                cf  = sum[WIDTH];
                vf  = (a_q[MSB] == b_q[MSB]) && (res[MSB] != a_q[MSB]);
            end
            OP_INC: begin
                sum = {1'b0, opnd} + ONE_W1;
                res = sum[WIDTH-1:0];
                cf  = sum[WIDTH];
            end
            OP_DEC: begin
                res = opnd - ONE_W;
                cf  = (opnd == '0);
            end
            OP_NOT: res = ~opnd;
            OP_SUB: begin
                sum = {1'b0, a_q} + {1'b0, ~b_q} + ONE_W1;
                res = sum[WIDTH-1:0];
                cf  = sum[WIDTH];
                vf  = (a_q[MSB] != b_q[MSB]) && (res[MSB] != a_q[MSB]);
            end
            OP_XOR: res = a_q ^ b_q;
            OP_SHL, OP_SHR: begin
                res = a_q;
                cf  = carry_q;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                res = b_q;
                cf  = |acc_q;
            end
`endif
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ALUResult <= '0;
            C         <= 1'b0;
            Z         <= 1'b0;
            S         <= 1'b0;
            V         <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            fin_q     <= 1'b0;
            carry_q   <= 1'b0;
            cnt       <= '0;
`ifdef ALU_SEQ_MUL_EN
            acc_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= ALUA;
                        b_q      <= ALUB;
                        op_q     <= ALUControl;
                        fin_q    <= ALUFlagIn;
                        carry_q  <= 1'b0;
                        cnt      <= steps;
`ifdef ALU_SEQ_MUL_EN
                        acc_q    <= '0;
`endif
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        ALUResult <= res;
                        C         <= cf;
                        Z         <= (res == '0);
                        S         <= res[MSB];
                        V         <= vf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        case (op_q)
                            OP_SHL: begin
                                carry_q <= a_q[MSB];
                                a_q     <= {a_q[WIDTH-2:0], fin_q};
                            end
                            OP_SHR: begin
                                carry_q <= a_q[0];
                                a_q     <= {fin_q, a_q[WIDTH-1:1]};
                            end
`ifdef ALU_SEQ_MUL_EN
                            OP_MUL: begin
                                acc_q <= mul_sum[WIDTH:1];
                                b_q   <= {mul_sum[0], b_q[WIDTH-1:1]};
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8); expectations follow ALU_SEQ_MUL_EN when defined.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ALUA;
    logic [7:0] ALUB;
    logic [3:0] ALUControl;
    logic       ALUFlagIn;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ALUResult;
    logic       C, Z, S, V;

    int nvec = 0;
    int nerr = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUA       (ALUA),
        .ALUB       (ALUB),
        .ALUControl (ALUControl),
        .ALUFlagIn  (ALUFlagIn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .C          (C),
        .Z          (Z),
        .S          (S),
        .V          (V)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic f);
        ALUControl = op;
        ALUA       = a;
        ALUB       = b;
        ALUFlagIn  = f;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic f, input logic [7:0] er, input logic ec, input logic ez,
                       input logic es, input logic ev, input int elat);
        int lat;
        issue(op, a, b, f);
        wait_valid(lat);
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".res"}, ALUResult, er);
        chk({tag, ".czsv"}, {C, Z, S, V}, {ec, ez, es, ev});
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUA = '0; ALUB = '0; ALUControl = '0; ALUFlagIn = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.res_flags", {ALUResult, C, Z, S, V}, 12'h000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        //  tag        op  A      B      f  res    C  Z  S  V  lat
        run("add_ci",  2, 8'hF0, 8'h20, 1, 8'h11, 1, 0, 0, 0, 1);
        run("add_ovf", 2, 8'h7F, 8'h01, 0, 8'h80, 0, 0, 1, 1, 1);
        run("sub_ovf", 6, 8'h80, 8'h01, 0, 8'h7F, 1, 0, 0, 1, 1);
        run("sub_brw", 6, 8'h01, 8'h02, 0, 8'hFF, 0, 0, 1, 0, 1);
        run("and",     0, 8'hCC, 8'hAA, 0, 8'h88, 0, 0, 1, 0, 1);
        run("or",      1, 8'hCC, 8'hAA, 0, 8'hEE, 0, 0, 1, 0, 1);
        run("xor",     7, 8'hCC, 8'hAA, 0, 8'h66, 0, 0, 0, 0, 1);
        run("inc_b",   3, 8'h12, 8'hFF, 1, 8'h00, 1, 1, 0, 0, 1);
        run("dec_a",   4, 8'h00, 8'h55, 0, 8'hFF, 1, 0, 1, 0, 1);
        run("not_a",   5, 8'h5A, 8'h00, 0, 8'hA5, 0, 0, 1, 0, 1);
        run("shl3",    8, 8'h81, 8'h03, 0, 8'h08, 0, 0, 0, 0, 4);
        run("shr1",    9, 8'h81, 8'h01, 1, 8'hC0, 1, 0, 1, 0, 2);
        run("shr_sat", 9, 8'h81, 8'd20, 0, 8'h00, 1, 1, 0, 0, 9);
        run("shl0",    8, 8'h3C, 8'h00, 1, 8'h3C, 0, 0, 0, 0, 1);
        run("shl8",    8, 8'h01, 8'h08, 1, 8'hFF, 1, 0, 1, 0, 9);
        run("rsvd12", 12, 8'hFF, 8'hFF, 1, 8'h00, 0, 1, 0, 0, 1);
`ifdef ALU_SEQ_MUL_EN
        run("mul_hi", 10, 8'h10, 8'h10, 1, 8'h00, 1, 1, 0, 0, 9);
        run("mul_lo", 10, 8'h0F, 8'h11, 0, 8'hFF, 0, 0, 1, 0, 9);
`else
        run("op10",   10, 8'h10, 8'h10, 1, 8'h00, 0, 1, 0, 0, 1);
`endif

        // Backpressure: result held, new request ignored until after the handoff
        out_ready = 1'b0;
        issue(2, 8'h01, 8'h02, 0);
        wait_valid(lat);
        chk("bp.lat", lat, 1);
        ALUControl = 4'd0; ALUA = 8'hF0; ALUB = 8'h3C; ALUFlagIn = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.hold", {out_valid, in_ready, ALUResult}, {1'b1, 1'b0, 8'h03});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.handoff", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        chk("bp.accept", in_ready, 0);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp.next_lat", lat, 1);
        chk("bp.next_res", ALUResult, 8'h30);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a 7-step shift
        issue(8, 8'h81, 8'h07, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst.out", {out_valid, in_ready, ALUResult, C, Z, S, V}, {1'b0, 1'b1, 8'h00, 4'h0});
        #10;
        chk("arst.held", {out_valid, in_ready}, 2'b01);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run("post_rst", 2, 8'h05, 8'h03, 0, 8'h08, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational ALU.
- Same opcode map for ops 0-9, generalised to WIDTH bits. Adds registered outputs, a valid/ready handshake on input and output, iterative 1-bit-per-cycle shifts, and extended flags (carry, zero, sign, overflow).
- Sits between the operand register file and the writeback stage of the lab datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNTW, $clog2(WIDTH+1), width of the internal shift/step counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and opcode valid
in_ready  out  1  block can accept an operation (high only in IDLE)
ALUA  in  WIDTH  operand A
ALUB  in  WIDTH  operand B / shift amount
ALUControl  in  4  opcode
ALUFlagIn  in  1  carry-in, operand select, or shift fill bit (per opcode)
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
ALUResult  out  WIDTH  result
C  out  1  carry/borrow/shift-out flag
Z  out  1  ALUResult == 0
S  out  1  ALUResult[WIDTH-1]
V  out  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, ALUResult=0, C=Z=S=V=0.
- Reset asserted mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_valid&&in_ready captures ALUA, ALUB, ALUControl, ALUFlagIn. Go to EXEC.
  - EXEC: single-step ops compute in one cycle. Shifts/MUL iterate. Go to DONE when the step counter reaches 0.
  - DONE: out_valid=1; outputs stay stable while out_ready=0. On out_ready=1, go to IDLE.
  - No new operation is accepted in the same cycle as the DONE handoff.
- Latency: accept at cycle T; out_valid rises at T+1+k.
  - k=0 for single-step ops.
  - k=min(ALUB,WIDTH) for shifts.
  - k=WIDTH for MUL.
- Opcodes:
  - 0 AND: A&B.
  - 1 OR: A|B.
  - 2 ADD: A+B+FlagIn. C=carry out; V=signed overflow.
  - 3 INC: (FlagIn ? B : A)+1. C=carry out.
  - 4 DEC: (FlagIn ? B : A)-1. C=borrow (operand==0).
  - 5 NOT: ~(FlagIn ? B : A). C=0.
  - 6 SUB: A+~B+1. C=carry out (1 when A>=B unsigned); V=signed overflow.
  - 7 XOR: A^B. C=0.
  - 8 SHL: one bit per EXEC cycle; FlagIn shifted into LSB; C=last bit shifted out of MSB.
  - 9 SHR: one bit per EXEC cycle; FlagIn shifted into MSB; C=last bit shifted out of LSB.
  - 10-15: result=0, C=V=0 (10 is MUL when the optional feature is enabled).
- Shift boundaries:
  - Shift amount 0: result=A, C=0, single-step latency.
  - ALUB>=WIDTH saturates to WIDTH steps, so the result is all fill bits and C=the original end bit.
- Flag rules: Z, S and V are derived from the final result; V=0 for all ops other than ADD/SUB.
- Arithmetic: all arithmetic is unsigned WIDTH-bit, modulo 2^WIDTH. Carries are computed using a WIDTH+1-bit internal sum.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 10 = MUL, unsigned shift-add, WIDTH EXEC cycles.
  - ALUResult = low WIDTH bits of A*B.
  - C=1 if the high WIDTH bits are nonzero.
  - V=0; FlagIn is ignored.
- Undefined: opcode 10 behaves as the other reserved opcodes (result 0, one step). No multiplier logic is synthesised.

Test Plan:
- WIDTH=8 ADD A=0xF0,B=0x20,FlagIn=1, out_ready=1 -> out_valid at T+1, ALUResult=0x11, C=1, V=0, Z=0, S=0.
- SUB A=0x80,B=0x01 -> ALUResult=0x7F, C=1, V=1, S=0; then SUB A=0x01,B=0x02 -> 0xFF, C=0, S=1.
- SHL A=0x81,B=3,FlagIn=0 -> out_valid at T+4, ALUResult=0x08, C=0; SHR A=0x81,B=1,FlagIn=1 -> T+2, 0xC0, C=1; SHR B=20 -> 0x00 after 8 steps, Z=1.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> outputs stable, in_ready=0; new in_valid ignored until the cycle after out_ready=1.
- Reset: assert rst_n=0 during EXEC of SHL B=7 -> out_valid=0, in_ready=1, all outputs 0 immediately (asynchronous); the next operation runs normally.
- ALU_SEQ_MUL_EN defined: MUL 0x10*0x10 -> T+9, ALUResult=0x00, Z=1, C=1. MUL 0x0F*0x11 -> 0xFF, C=0. Undefined: opcode 10 -> 0x00 at T+1.
